// File: rtl/apb_pkg.sv
// Shared types and constants for the APB request master and its timeout counter.
package apb_pkg;

  localparam int unsigned DATA_W          = 8;
  localparam int unsigned ADDR_W          = 8;
  localparam int unsigned SEL_W           = 2;
  localparam int unsigned CNT_W           = 8;
  localparam int unsigned TIMEOUT_DEFAULT = 255;

  localparam logic [SEL_W-1:0] SEL_NONE = 2'b00;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_e;

  // One single-beat processor request as carried through the buffer and onto APB.
  typedef struct packed {
    logic              write;
    logic [SEL_W-1:0]  sel;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] wait_cycles;
  } req_t;

endpackage

// File: rtl/apb_request_master_if.sv
// Processor-side request signals and APB master signals of the request master.
interface apb_request_master_if;
  import apb_pkg::*;

  logic              p_start;
  logic              p_write;
  logic [SEL_W-1:0]  p_sel;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_wdata;
  logic [DATA_W-1:0] p_wait_cycles;
  logic [DATA_W-1:0] p_rdata;
  logic              p_stable;
  logic              p_error;
  logic              p_busy;
  logic              p_overflow;

  logic [SEL_W-1:0]  apb_sel;
  logic              apb_write;
  logic              apb_enable;
  logic [ADDR_W-1:0] apb_addr;
  logic [DATA_W-1:0] apb_wdata;
  logic [DATA_W-1:0] apb_wait_cycles;
  logic              apb_ready;
  logic [DATA_W-1:0] apb_rdata;

  // View of the request master itself.
  modport master (
    input  p_start, p_write, p_sel, p_addr, p_wdata, p_wait_cycles,
    output p_rdata, p_stable, p_error, p_busy, p_overflow,
    output apb_sel, apb_write, apb_enable, apb_addr, apb_wdata, apb_wait_cycles,
    input  apb_ready, apb_rdata
  );

  // View of the surrounding processor and slave side.
  modport slave (
    output p_start, p_write, p_sel, p_addr, p_wdata, p_wait_cycles,
    input  p_rdata, p_stable, p_error, p_busy, p_overflow,
    input  apb_sel, apb_write, apb_enable, apb_addr, apb_wdata, apb_wait_cycles,
    output apb_ready, apb_rdata
  );

endinterface

// File: rtl/apb_timeout_counter.sv
// Counts ready-low ACCESS cycles; expired is high during the cycle whose
// increment would reach LIMIT.
module apb_timeout_counter
  import apb_pkg::*;
#(
  parameter int unsigned LIMIT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             expired_q, expired_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + CNT_W'(1);
    end
    expired_d = (count_d == CNT_W'(LIMIT - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      expired_q <= expired_d;
    end
  end

  assign expired = expired_q;

endmodule

// File: rtl/apb_request_master.sv
// Converts processor read/write requests into APB SETUP/ACCESS transfers with a
// one-deep request buffer, read-data return and ready timeout.
module apb_request_master
  import apb_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input logic                  clk,
  input logic                  reset,
  apb_request_master_if.master bus
);

  state_e            state_q, state_d;
  req_t              cur_q, cur_d;
  req_t              buf_q, buf_d;
  logic              buf_valid_q, buf_valid_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] p_rdata_q, p_rdata_d;
  logic              p_stable_q, p_stable_d;
  logic              p_error_q, p_error_d;
  logic              p_busy_q, p_busy_d;
  logic              p_overflow_q, p_overflow_d;
  req_t              apb_req_q, apb_req_d;
  logic              apb_enable_q, apb_enable_d;

  req_t p_req_c;
  logic drain_c;
  logic take_start_c;
  logic cnt_clear_c;
  logic cnt_en_c;
  logic cnt_expired;

  always_comb begin
    p_req_c.write       = bus.p_write;
    p_req_c.sel         = bus.p_sel;
    p_req_c.addr        = bus.p_addr;
    p_req_c.wdata       = bus.p_wdata;
    p_req_c.wait_cycles = bus.p_wait_cycles;
  end

  apb_timeout_counter #(
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (reset),
    .clear   (cnt_clear_c),
    .enable  (cnt_en_c),
    .expired (cnt_expired)
  );

  // Next-state, buffer management and registered-output computation.
  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    buf_d        = buf_q;
    buf_valid_d  = buf_valid_q;
    err_d        = err_q;
    p_rdata_d    = p_rdata_q;
    p_overflow_d = 1'b0;
    drain_c      = 1'b0;
    cnt_clear_c  = 1'b1;
    cnt_en_c     = 1'b0;

    case (state_q)
      IDLE: begin
        if (buf_valid_q) begin
          cur_d   = buf_q;
          drain_c = 1'b1;
          state_d = SETUP;
        end else if (bus.p_start) begin
          cur_d   = p_req_c;
          state_d = SETUP;
        end
      end
      SETUP: begin
        err_d   = (cur_q.sel == SEL_NONE);
        state_d = (cur_q.sel == SEL_NONE) ? DONE : ACCESS;
      end
      ACCESS: begin
        cnt_clear_c = 1'b0;
        cnt_en_c    = !bus.apb_ready;
        if (bus.apb_ready) begin
          if (!cur_q.write) begin
            p_rdata_d = bus.apb_rdata;
          end
          state_d = DONE;
        end else if (cnt_expired) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (buf_valid_q) begin
          cur_d   = buf_q;
          drain_c = 1'b1;
          state_d = SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A start goes to the buffer unless IDLE consumed it directly; a draining buffer frees its slot.
    take_start_c = bus.p_start && ((state_q != IDLE) || buf_valid_q);
    if (take_start_c) begin
      if (!buf_valid_q || drain_c) begin
        buf_d       = p_req_c;
        buf_valid_d = 1'b1;
      end else begin
        p_overflow_d = 1'b1;
      end
    end else if (drain_c) begin
      buf_valid_d = 1'b0;
    end

    p_stable_d   = (state_d == DONE);
    p_error_d    = (state_d == DONE) && err_d;
    p_busy_d     = (state_d != IDLE) || buf_valid_d;
    apb_enable_d = (state_d == ACCESS);
    apb_req_d    = ((state_d == SETUP) || (state_d == ACCESS)) ? cur_d : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cur_q        <= '0;
      buf_q        <= '0;
      buf_valid_q  <= 1'b0;
      err_q        <= 1'b0;
      p_rdata_q    <= '0;
      p_stable_q   <= 1'b0;
      p_error_q    <= 1'b0;
      p_busy_q     <= 1'b0;
      p_overflow_q <= 1'b0;
      apb_req_q    <= '0;
      apb_enable_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      buf_q        <= buf_d;
      buf_valid_q  <= buf_valid_d;
      err_q        <= err_d;
      p_rdata_q    <= p_rdata_d;
      p_stable_q   <= p_stable_d;
      p_error_q    <= p_error_d;
      p_busy_q     <= p_busy_d;
      p_overflow_q <= p_overflow_d;
      apb_req_q    <= apb_req_d;
      apb_enable_q <= apb_enable_d;
    end
  end

  assign bus.p_rdata         = p_rdata_q;
  assign bus.p_stable        = p_stable_q;
  assign bus.p_error         = p_error_q;
  assign bus.p_busy          = p_busy_q;
  assign bus.p_overflow      = p_overflow_q;
  assign bus.apb_sel         = apb_req_q.sel;
  assign bus.apb_write       = apb_req_q.write;
  assign bus.apb_enable      = apb_enable_q;
  assign bus.apb_addr        = apb_req_q.addr;
  assign bus.apb_wdata       = apb_req_q.wdata;
  assign bus.apb_wait_cycles = apb_req_q.wait_cycles;

endmodule

// File: tb/tb_apb_request_master.sv
// Scoreboard bench for apb_request_master: directed requests push expected
// completions, a negedge monitor pops and compares them.
module tb_apb_request_master;
  import apb_pkg::*;

  localparam int unsigned TMO = 4;

  typedef struct {
    int         cyc;
    logic       err;
    logic [7:0] rdata;
  } cpl_t;

  logic clk = 1'b0;
  logic reset;

  apb_request_master_if bus ();

  apb_request_master #(
    .TIMEOUT (TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  cpl_t cpl_q[$];
  req_t apb_q[$];
  int   ovf_q[$];

  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_stable = 0;
  int         ready_delay = 0;
  logic [7:0] slave_rdata = 8'h00;
  bit         en_seen = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Slave model: ready rises after ready_delay ACCESS cycles.
  initial begin
    int acc_cnt;
    acc_cnt = 0;
    bus.apb_ready = 1'b0;
    bus.apb_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.apb_enable) begin
        bus.apb_ready = (acc_cnt >= ready_delay);
        bus.apb_rdata = slave_rdata;
        acc_cnt++;
      end else begin
        acc_cnt = 0;
        bus.apb_ready = 1'b0;
      end
    end
  end

  // Monitor: compares every completion, APB payload and overflow pulse.
  initial begin
    logic prev_en;
    cpl_t e;
    req_t er, ar;
    int   eo;
    prev_en = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.apb_enable) en_seen = 1'b1;
      if (bus.apb_enable && !prev_en) begin
        if (apb_q.size() == 0) begin
          chk("unexpected_access", 64'(bus.apb_addr), 64'hFFFF);
        end else begin
          er = apb_q.pop_front();
          ar.write       = bus.apb_write;
          ar.sel         = bus.apb_sel;
          ar.addr        = bus.apb_addr;
          ar.wdata       = bus.apb_wdata;
          ar.wait_cycles = bus.apb_wait_cycles;
          chk("apb_payload", 64'(ar), 64'(er));
        end
      end
      prev_en = bus.apb_enable;
      if (bus.p_error && !bus.p_stable) chk("error_without_stable", 64'(bus.p_stable), 64'd1);
      if (bus.p_stable) begin
        n_stable++;
        if (cpl_q.size() == 0) begin
          chk("unexpected_stable", 64'(bus.p_stable), 64'd0);
        end else begin
          e = cpl_q.pop_front();
          chk("stable_cycle", 64'(cyc), 64'(e.cyc));
          chk("p_error", 64'(bus.p_error), 64'(e.err));
          chk("p_rdata", 64'(bus.p_rdata), 64'(e.rdata));
        end
      end
      if (bus.p_overflow) begin
        if (ovf_q.size() == 0) begin
          chk("unexpected_overflow", 64'(bus.p_overflow), 64'd0);
        end else begin
          eo = ovf_q.pop_front();
          chk("overflow_cycle", 64'(cyc), 64'(eo));
        end
      end
    end
  end

  // Drive one start in the current cycle and record what it should produce.
  task automatic issue(input logic w, input logic [1:0] s, input logic [7:0] a,
                       input logic [7:0] wd, input logic [7:0] wc, input int lat,
                       input logic exp_err, input logic [7:0] exp_rd,
                       input bit exp_cpl, input bit exp_apb, input bit exp_ovf);
    req_t r;
    bus.p_start       = 1'b1;
    bus.p_write       = w;
    bus.p_sel         = s;
    bus.p_addr        = a;
    bus.p_wdata       = wd;
    bus.p_wait_cycles = wc;
    r.write = w; r.sel = s; r.addr = a; r.wdata = wd; r.wait_cycles = wc;
    if (exp_ovf) ovf_q.push_back(cyc + 1);
    if (exp_cpl) cpl_q.push_back('{cyc + lat, exp_err, exp_rd});
    if (exp_apb) apb_q.push_back(r);
    @(negedge clk);
  endtask

  task automatic drain();
    bus.p_start = 1'b0;
    for (int i = 0; i < 40 && (cpl_q.size() != 0 || ovf_q.size() != 0 || bus.p_busy); i++)
      @(negedge clk);
    chk("pending_completions", 64'(cpl_q.size() + ovf_q.size()), 64'd0);
    chk("busy_after_drain", 64'(bus.p_busy), 64'd0);
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, {bus.p_rdata, bus.p_stable, bus.p_error, bus.p_busy, bus.p_overflow,
             bus.apb_sel, bus.apb_write, bus.apb_enable, bus.apb_addr,
             bus.apb_wdata, bus.apb_wait_cycles}, 64'd0);
  endtask

  initial begin
    int st0;
    reset = 1'b0;
    bus.p_start = 1'b0; bus.p_write = 1'b0; bus.p_sel = 2'd0;
    bus.p_addr = 8'h00; bus.p_wdata = 8'h00; bus.p_wait_cycles = 8'h00;
    repeat (3) @(negedge clk);
    chk_all_zero("reset_outputs");
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Zero-wait write: stable 3 cycles after the start cycle.
    ready_delay = 0;
    issue(1'b1, 2'd1, 8'h10, 8'hA5, 8'h00, 3, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    bus.p_start = 1'b0;
    chk("busy_rise", 64'(bus.p_busy), 64'd1);
    drain();

    // Read with three ready-low ACCESS cycles.
    ready_delay = 3; slave_rdata = 8'h5C;
    issue(1'b0, 2'd2, 8'h20, 8'h00, 8'h03, 6, 1'b0, 8'h5C, 1'b1, 1'b1, 1'b0);
    drain();

    // Timeout after TMO ready-low cycles; read data must not change.
    ready_delay = 1000; slave_rdata = 8'hEE;
    issue(1'b0, 2'd1, 8'h30, 8'h00, 8'h09, 6, 1'b1, 8'h5C, 1'b1, 1'b1, 1'b0);
    drain();
    chk("rdata_after_timeout", 64'(bus.p_rdata), 64'h5C);

    // Three consecutive starts: run, buffered, dropped.
    ready_delay = 0; slave_rdata = 8'h33;
    st0 = n_stable;
    issue(1'b0, 2'd1, 8'h40, 8'h00, 8'h00, 3, 1'b0, 8'h33, 1'b1, 1'b1, 1'b0);
    issue(1'b1, 2'd2, 8'h41, 8'h77, 8'h01, 5, 1'b0, 8'h33, 1'b1, 1'b1, 1'b0);
    issue(1'b1, 2'd3, 8'h42, 8'h88, 8'h00, 0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    drain();
    chk("two_stables", 64'(n_stable - st0), 64'd2);

    // Start in the cycle the buffer drains is accepted.
    slave_rdata = 8'h66;
    issue(1'b1, 2'd1, 8'h50, 8'h11, 8'h00, 3, 1'b0, 8'h33, 1'b1, 1'b1, 1'b0);
    issue(1'b1, 2'd2, 8'h51, 8'h22, 8'h00, 5, 1'b0, 8'h33, 1'b1, 1'b1, 1'b0);
    bus.p_start = 1'b0;
    @(negedge clk);
    issue(1'b0, 2'd3, 8'h52, 8'h00, 8'h00, 6, 1'b0, 8'h66, 1'b1, 1'b1, 1'b0);
    drain();

    // sel=0: error completion, no APB access.
    en_seen = 1'b0;
    issue(1'b0, 2'd0, 8'h60, 8'h00, 8'h00, 2, 1'b1, 8'h66, 1'b1, 1'b0, 1'b0);
    drain();
    chk("sel0_no_enable", 64'(en_seen), 64'd0);

    // Reset in ACCESS: outputs clear at once and no completion follows.
    ready_delay = 1000;
    issue(1'b0, 2'd1, 8'h70, 8'h00, 8'h00, 0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    bus.p_start = 1'b0;
    @(negedge clk);
    chk("in_access", 64'(bus.apb_enable), 64'd1);
    #2 reset = 1'b0;
    #1 chk_all_zero("async_reset_outputs");
    st0 = n_stable;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    chk("no_stable_after_reset", 64'(n_stable - st0), 64'd0);

    // Recovery write after reset.
    ready_delay = 0;
    issue(1'b1, 2'd2, 8'h80, 8'h5A, 8'h02, 3, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    drain();
    chk("apb_queue_empty", 64'(apb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_request_master.md
# apb_request_master

Master-side stage of the APB subsystem: accepts single-beat read/write requests from the processor side (Processor_Bus signal set) and converts them into APB SETUP/ACCESS transfers toward the APB_Slave instances (APB_Bus master signal set). Sits directly upstream of the slaves. It has three further duties:
- Buffers one pending request so back-to-back processor starts are not lost.
- Returns read data with a one-cycle `stable` pulse.
- Aborts transfers whose slave never raises `ready`.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum number of ACCESS cycles with `ready` low before the transfer aborts (range 1..255).

Ports:
- `clk`  input  1  single system clock; all state changes on its rising edge.
- `reset`  input  1  asynchronous, active-low reset. Asserting it (0) clears all state immediately.
- `p_start`  input  1  processor request strobe, sampled each rising edge.
- `p_write`  input  1  1 = write, 0 = read.
- `p_sel`  input  2  target slave id; 0 = no slave.
- `p_addr`  input  8  transfer address.
- `p_wdata`  input  8  write data.
- `p_wait_cycles`  input  8  wait states requested from the slave; forwarded unchanged.
- `p_rdata`  output  8  data from the last completed read.
- `p_stable`  output  1  one-cycle pulse marking completion of a transfer.
- `p_error`  output  1  one-cycle pulse, coincident with `p_stable`, on timeout or `sel`=0.
- `p_busy`  output  1  high when a transfer is in flight or the buffer holds a request.
- `p_overflow`  output  1  one-cycle pulse when a start is dropped because the buffer is full.
- `apb_sel`, `apb_write`, `apb_enable`  output  2/1/1  APB control.
- `apb_addr`, `apb_wdata`, `apb_wait_cycles`  output  8 each  APB payload.
- `apb_ready`  input  1  muxed slave ready.
- `apb_rdata`  input  8  muxed slave read data.

## Operation
States: IDLE, SETUP, ACCESS, DONE.
- **IDLE**
  - `apb_sel`=0 and `apb_enable`=0.
  - If the buffer holds a request, go to SETUP using the buffered request.
  - Otherwise, `p_start`=1 captures the `p_*` request and goes to SETUP.
- **SETUP** (exactly one cycle)
  - Drive `apb_sel`, `apb_addr`, `apb_write`, `apb_wdata`, `apb_wait_cycles` from the captured request; `apb_enable`=0.
  - Go to ACCESS.
  - If the captured `sel` is 0, go directly to DONE with error; no APB cycle is issued.
- **ACCESS**
  - Hold all SETUP values and drive `apb_enable`=1.
  - `apb_ready`=1 at a rising edge: a read latches `apb_rdata` into `p_rdata`; go to DONE.
  - The timeout counter increments on every ACCESS cycle with `ready` low. Reaching `TIMEOUT`: go to DONE with error. `p_rdata` is unchanged on error.
- **DONE** (one cycle)
  - Pulse `p_stable`; pulse `p_error` if flagged.
  - `apb_sel`=0, `apb_enable`=0.
  - If the buffer is non-empty, go to SETUP; otherwise go to IDLE.
- **Start while busy** (any state other than IDLE):
  - If the buffer is empty, the request is captured into the buffer.
  - If the buffer is full, the request is dropped and `p_overflow` is pulsed.
  - A start arriving in the same cycle the buffer drains (DONE→SETUP) is accepted into the buffer.
- Write transfers leave `p_rdata` unchanged.
- **Reset**
  - Any state → IDLE; the buffer is cleared.
  - All outputs go to 0: `p_rdata`, `p_stable`, `p_error`, `p_busy`, `p_overflow` and all `apb_*` outputs.
  - A transfer in progress is abandoned with no `p_stable`.

## Timing
- Start sampled at edge N → SETUP in cycle N+1, ACCESS in N+2.
- With `ready` high on the first ACCESS edge, `p_stable` pulses in cycle N+3: 3 cycles start-to-stable.
- Each ACCESS cycle with `ready` low adds one cycle.
- Timeout: `p_stable` and `p_error` pulse one cycle after the `TIMEOUT`-th ready-low ACCESS cycle.
- `p_rdata` is valid in the same cycle as `p_stable` and holds until the next successful read.
- Back-to-back requests from the buffer: DONE is followed directly by SETUP, so there is a 3-cycle period per zero-wait transfer.
- `p_busy` is registered and rises in the cycle after an accepted start.

## Structure
- Package `apb_pkg` holds:
  - the state enum (IDLE, SETUP, ACCESS, DONE);
  - a request struct (write, sel, addr, wdata, wait_cycles);
  - `SEL_NONE` = 2'b00;
  - the default `TIMEOUT`.
- One sub-module, `apb_timeout_counter`: an 8-bit counter with clear and enable inputs and an `expired` output.

## Test plan
- Write: reset released, start with write=1, sel=1, addr=0x10, wdata=0xA5, wait=0, ready high → SETUP then ACCESS; `p_stable` at start+3; no error.
- Read with wait: read from sel=2, addr=0x20; ready low for 3 ACCESS cycles, then high with rdata=0x5C → `p_rdata`=0x5C and `p_stable` at start+6.
- Timeout: `TIMEOUT`=4, ready held low → `p_stable` and `p_error` pulse after 4 ACCESS cycles; `p_rdata` unchanged; returns to IDLE.
- Buffering: three starts on consecutive cycles → the first runs, the second is buffered and runs back-to-back, the third pulses `p_overflow`; exactly two `p_stable` pulses.
- sel=0 and reset: a sel=0 request → error completion with `apb_enable` never 1. Asserting `reset`=0 during ACCESS → all outputs 0 immediately; no `p_stable`.
